jk_sync_mod_counter: RTL and testbench
======================================

// Module: jk_sync_mod_counter
// PURPOSE
//   Parametrised synchronous up/down modulo counter, built from JK flip-flop cells.
//   Supersedes the fixed 4-bit asynchronous ripple counter.
//   - All bits update on the same clock edge: no ripple skew, no transient codes.
//   - Adds hold/up/down/load modes, a programmable modulus, synchronous reset,
//     and a terminal-count output for cascading into wider/BCD chains.
//   - Used as the general-purpose event/divider counter in the sequential-logic set.
// PARAMETERS
//   WIDTH      4    counter width in bits (>=1)
//   MODULUS    16   count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
//   RESET_VAL  0    value of Q after reset; must be < MODULUS
// PORTS
//   clock     in   1      single clock; all state changes on posedge
//   reset     in   1      synchronous, active-high
//   en        in   1      count enable / cascade carry-in; gates up, down and load
//   mode      in   2      00 hold, 01 up, 10 down, 11 load
//   load_val  in   WIDTH  parallel load value, used when mode=11
//   Q         out  WIDTH  registered count
//   tc        out  1      combinational terminal count / carry-out
//   wrap      out  1      registered one-cycle pulse: previous edge wrapped
// BEHAVIOUR
//   - Reset: reset=1 at posedge -> Q=RESET_VAL, wrap=0.
//     - Overrides en and mode.
//     - Mid-count reset takes effect on that edge; no partial update.
//     - tc follows the reset value combinationally.
//   - en=0 or mode=00: Q holds; wrap=0 on the next edge.
//   - Up (en=1, mode=01):
//     - Q<=Q+1 when Q<MODULUS-1.
//     - Q==MODULUS-1 -> Q<=0 and wrap<=1.
//   - Down (en=1, mode=10):
//     - Q<=Q-1 when Q>0.
//     - Q==0 -> Q<=MODULUS-1 and wrap<=1.
//   - Load (en=1, mode=11):
//     - Q<=load_val; wrap<=0.
//     - load_val>=MODULUS is clamped: Q<=MODULUS-1.
//   - Any Q>=MODULUS (unreachable after reset; reachable only via X or illegal state):
//     - up or down forces Q<=0.
//   - tc = en & ((mode==01 & Q==MODULUS-1) | (mode==10 & Q==0)).
//     - tc=0 in hold and load.
//     - Cascade: tc of stage n drives en of stage n+1, same mode, same clock.
//   - wrap is high for exactly one cycle per wrap event.
//     - Continuous counting with MODULUS=2 toggles wrap every other cycle.
//   - Latency:
//     - Q and wrap: one cycle from the sampled inputs.
//     - tc: zero cycles from Q, en and mode.
//   - Power-of-two MODULUS: plain binary toggle chain, no compare logic needed.
//   - Implementation: each bit is one JK cell.
//     - Next-state logic drives J/K per bit: J=K=1 toggle, J=1/K=0 set,
//       J=0/K=1 clear, J=K=0 hold.
//     - Binary count: bit i toggles when en, and all lower bits are 1 (up) or 0 (down).
//     - Wrap and load use set/clear encoding from the target value.
//   - No combinational path from load_val to tc.
// STRUCTURE
//   - Shared package (counter_pkg): mode encodings MODE_HOLD=2'b00, MODE_UP=2'b01,
//     MODE_DOWN=2'b10, MODE_LOAD=2'b11.
//   - Sub-module jk_ff_sync (clock, reset, rst_val, j, k, q): one bit.
//     - Synchronous active-high reset to rst_val.
//     - JK truth table: 00 hold, 01 clear, 10 set, 11 toggle.
//     - Instantiated WIDTH times via generate; rst_val = RESET_VAL[i].
//   - Top level holds only the J/K next-state logic, the tc decode and the wrap register.
// TESTING  (WIDTH=4, MODULUS=10, RESET_VAL=0 unless noted)
//   1. reset=1 for 2 cycles, then en=1, mode=01 for 12 cycles.
//      -> Q = 0,1..9,0,1.
//      -> tc=1 only while Q=9.
//      -> wrap=1 only in the cycle Q=0 follows 9.
//   2. Q=3, then mode=10 for 5 cycles.
//      -> Q = 2,1,0,9,8.
//      -> tc=1 while Q=0.
//      -> wrap=1 in the cycle Q=9 appears.
//   3. mode=11, load_val=7, then load_val=13.
//      -> Q=7, then Q=9 (clamped); wrap stays 0.
//   4. Counting up with Q=5, assert reset for 1 cycle with en=1.
//      -> next Q=0, wrap=0; counting resumes 1,2,... afterwards.
//   5. Toggle en 1,0,1,0 in mode 01 from Q=8.
//      -> Q = 9,9,0,0.
//      -> tc=0 whenever en=0.
//   6. Two instances cascaded (lo.tc->hi.en), WIDTH=4, MODULUS=10, 100 up clocks.
//      -> {hi,lo} counts 00..99 in BCD, then returns to 00.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the JK-based counter family.
// The mode encoding is common to every counter stage so that cascaded stages agree.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage

// File: rtl/jk_ff_sync.sv
// Single JK flip-flop cell with synchronous active-high reset to a per-bit value.
module jk_ff_sync (
  input  logic clock,
  input  logic reset,
  input  logic rst_val,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= rst_val;
    end else begin
      unique case ({j, k})
        2'b00:   q <= q;
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/jk_sync_mod_counter.sv
// Synchronous up/down modulo counter: every bit is a JK cell clocked on the same edge.
// Binary steps use per-bit toggles; wrap, load and illegal-state recovery use set/clear.
module jk_sync_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MODULUS   = 16,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MaxVal    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RstVal    = WIDTH'(RESET_VAL);
  localparam logic [WIDTH:0]   ModExt    = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH:0]   FullRange = {1'b1, {WIDTH{1'b0}}};
  // A full binary range wraps by itself through the toggle chain.
  localparam bit               Pow2      = (ModExt == FullRange);

  if (WIDTH < 1) begin : g_bad_width
    $error("jk_sync_mod_counter: WIDTH must be at least 1");
  end
  if (MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("jk_sync_mod_counter: MODULUS out of range");
  end
  if (RESET_VAL >= MODULUS) begin : g_bad_reset
    $error("jk_sync_mod_counter: RESET_VAL must be below MODULUS");
  end

  mode_e            mode_s;
  logic             at_max;
  logic             at_zero;
  logic             out_of_range;
  logic [WIDTH-1:0] load_tgt;
  logic [WIDTH-1:0] up_tgl;
  logic [WIDTH-1:0] dn_tgl;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] tgl;
  logic             use_tgt;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             wrap_q;

  assign mode_s       = mode_e'(mode);
  assign at_max       = (Q == MaxVal);
  assign at_zero      = (Q == '0);
  assign out_of_range = !Pow2 && ({1'b0, Q} >= ModExt);
  assign load_tgt     = ({1'b0, load_val} >= ModExt) ? MaxVal : load_val;

  // Bit i toggles once every lower bit is 1 (up) or 0 (down).
  assign up_tgl[0] = 1'b1;
  assign dn_tgl[0] = 1'b1;
  for (genvar g = 1; g < WIDTH; g++) begin : g_chain
    assign up_tgl[g] = &Q[g-1:0];
    assign dn_tgl[g] = ~|Q[g-1:0];
  end

  // Depends only on Q, en and mode so cascades see no load_val path.
  assign tc = en & (((mode_s == MODE_UP) & at_max) | ((mode_s == MODE_DOWN) & at_zero));

  always_comb begin
    use_tgt = 1'b0;
    tgt     = '0;
    tgl     = '0;
    if (en) begin
      unique case (mode_s)
        MODE_HOLD: ;
        MODE_UP: begin
          if (out_of_range || (at_max && !Pow2)) begin
            use_tgt = 1'b1;
          end else begin
            tgl = up_tgl;
          end
        end
        MODE_DOWN: begin
          if (out_of_range) begin
            use_tgt = 1'b1;
          end else if (at_zero && !Pow2) begin
            use_tgt = 1'b1;
            tgt     = MaxVal;
          end else begin
            tgl = dn_tgl;
          end
        end
        MODE_LOAD: begin
          use_tgt = 1'b1;
          tgt     = load_tgt;
        end
        default: ;
      endcase
    end
    j = use_tgt ? tgt  : tgl;
    k = use_tgt ? ~tgt : tgl;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff_sync u_ff (
      .clock   (clock),
      .reset   (reset),
      .rst_val (RstVal[i]),
      .j       (j[i]),
      .k       (k[i]),
      .q       (Q[i])
    );
  end

  // A wrap happens exactly when the terminal count is taken on an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= tc;
    end
  end

  assign wrap = wrap_q;

endmodule

// File: tb/tb_jk_sync_mod_counter.sv
// Bench for jk_sync_mod_counter: directed vector table, randomized run against an
// integer model, and a two-stage BCD cascade.
module tb_jk_sync_mod_counter;

  localparam int M = 10;

  logic       clock = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tc;
  logic       wrap;

  logic       c_rst;
  logic       c_en;
  logic [1:0] c_mode;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, hi_tc, lo_wrap, hi_wrap;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  jk_sync_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut (
    .clock(clock), .reset(reset), .en(en), .mode(mode), .load_val(load_val),
    .Q(q), .tc(tc), .wrap(wrap)
  );

  jk_sync_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_lo (
    .clock(clock), .reset(c_rst), .en(c_en), .mode(c_mode), .load_val(4'd0),
    .Q(lo_q), .tc(lo_tc), .wrap(lo_wrap)
  );

  jk_sync_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_hi (
    .clock(clock), .reset(c_rst), .en(lo_tc), .mode(c_mode), .load_val(4'd0),
    .Q(hi_q), .tc(hi_tc), .wrap(hi_wrap)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] lv;
    logic       exp_tc;
    logic [3:0] exp_q;
    logic       exp_w;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state
  int m_q = 0;
  bit m_w = 1'b0;

  task automatic add(input string name, input logic r, input logic e, input logic [1:0] m,
                     input logic [3:0] lv, input logic t, input logic [3:0] eq,
                     input logic w);
    vec_t v;
    v.name = name; v.rst = r; v.en = e; v.mode = m; v.lv = lv;
    v.exp_tc = t; v.exp_q = eq; v.exp_w = w;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit model_tc(input bit e, input int md);
    return e && ((md == 1 && m_q == M - 1) || (md == 2 && m_q == 0));
  endfunction

  task automatic model_step(input bit r, input bit e, input int md, input int lv);
    if (r) begin
      m_q = 0; m_w = 0;
    end else if (!e || md == 0) begin
      m_w = 0;
    end else if (md == 1) begin
      m_w = (m_q == M - 1);
      m_q = m_w ? 0 : m_q + 1;
    end else if (md == 2) begin
      m_w = (m_q == 0);
      m_q = m_w ? M - 1 : m_q - 1;
    end else begin
      m_w = 0;
      m_q = (lv >= M) ? M - 1 : lv;
    end
  endtask

  // Drive one cycle; tc is sampled before the edge, Q and wrap after it.
  task automatic drive(input logic r, input logic e, input logic [1:0] m, input logic [3:0] lv,
                       output logic tc_s, output logic [3:0] q_s, output logic w_s);
    reset = r; en = e; mode = m; load_val = lv;
    #1;
    tc_s = tc;
    @(posedge clock);
    #1;
    q_s = q;
    w_s = wrap;
    model_step(r, e, int'(m), int'(lv));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       tc_s, w_s;
    logic [3:0] q_s;
    bit         e, r;
    int         md, lv, exp_tc;

    reset = 1'b1; en = 1'b0; mode = 2'b00; load_val = '0;
    c_rst = 1'b1; c_en = 1'b0; c_mode = 2'b01;

    // Reset, then count up through a wrap
    add("reset0", 1, 0, 2'b00, 0, 0, 0, 0);
    add("reset1", 1, 0, 2'b00, 0, 0, 0, 0);
    add("up0",  0, 1, 2'b01, 0, 0, 1, 0);
    add("up1",  0, 1, 2'b01, 0, 0, 2, 0);
    add("up2",  0, 1, 2'b01, 0, 0, 3, 0);
    add("up3",  0, 1, 2'b01, 0, 0, 4, 0);
    add("up4",  0, 1, 2'b01, 0, 0, 5, 0);
    add("up5",  0, 1, 2'b01, 0, 0, 6, 0);
    add("up6",  0, 1, 2'b01, 0, 0, 7, 0);
    add("up7",  0, 1, 2'b01, 0, 0, 8, 0);
    add("up8",  0, 1, 2'b01, 0, 0, 9, 0);
    add("up9",  0, 1, 2'b01, 0, 1, 0, 1);
    add("up10", 0, 1, 2'b01, 0, 0, 1, 0);
    add("up11", 0, 1, 2'b01, 0, 0, 2, 0);
    // Down through zero
    add("ld3",  0, 1, 2'b11, 3, 0, 3, 0);
    add("dn3",  0, 1, 2'b10, 0, 0, 2, 0);
    add("dn2",  0, 1, 2'b10, 0, 0, 1, 0);
    add("dn1",  0, 1, 2'b10, 0, 0, 0, 0);
    add("dn0",  0, 1, 2'b10, 0, 1, 9, 1);
    add("dn9",  0, 1, 2'b10, 0, 0, 8, 0);
    // Load and clamp
    add("ld7",  0, 1, 2'b11, 7,  0, 7, 0);
    add("ld13", 0, 1, 2'b11, 13, 0, 9, 0);
    add("ld_noen", 0, 0, 2'b11, 2, 0, 9, 0);
    add("hold9",   0, 1, 2'b00, 0, 0, 9, 0);
    add("ld15", 0, 1, 2'b11, 15, 0, 9, 0);
    // Mid-count reset
    add("ld4",  0, 1, 2'b11, 4, 0, 4, 0);
    add("up_4", 0, 1, 2'b01, 0, 0, 5, 0);
    add("rst_mid", 1, 1, 2'b01, 0, 0, 0, 0);
    add("resume1", 0, 1, 2'b01, 0, 0, 1, 0);
    add("resume2", 0, 1, 2'b01, 0, 0, 2, 0);
    // Reset at terminal count suppresses the wrap pulse
    add("ld9b",   0, 1, 2'b11, 9, 0, 9, 0);
    add("rst_tc", 1, 1, 2'b01, 0, 1, 0, 0);
    // Enable gating
    add("ld8",  0, 1, 2'b11, 8, 0, 8, 0);
    add("en1a", 0, 1, 2'b01, 0, 0, 9, 0);
    add("en0a", 0, 0, 2'b01, 0, 0, 9, 0);
    add("en1b", 0, 1, 2'b01, 0, 1, 0, 1);
    add("en0b", 0, 0, 2'b01, 0, 0, 0, 0);
    add("dn_noen", 0, 0, 2'b10, 0, 0, 0, 0);
    add("ld0_at0", 0, 1, 2'b11, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].lv, tc_s, q_s, w_s);
      chk({vecs[i].name, ".tc"}, 32'(tc_s), 32'(vecs[i].exp_tc));
      chk({vecs[i].name, ".q"},  32'(q_s),  32'(vecs[i].exp_q));
      chk({vecs[i].name, ".wrap"}, 32'(w_s), 32'(vecs[i].exp_w));
    end

    // Randomized run against the model
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 31) == 0);
      e  = ($urandom_range(0, 3) != 0);
      md = $urandom_range(0, 3);
      lv = $urandom_range(0, 15);
      exp_tc = int'(model_tc(e, md));
      drive(r, e, 2'(md), 4'(lv), tc_s, q_s, w_s);
      chk("rand.tc", 32'(tc_s), 32'(exp_tc));
      chk("rand.q", 32'(q_s), 32'(m_q));
      chk("rand.wrap", 32'(w_s), 32'(m_w));
    end

    // Two-stage BCD cascade
    reset = 1'b1; en = 1'b0;
    c_rst = 1'b1; c_en = 1'b1; c_mode = 2'b01;
    @(posedge clock);
    #1;
    chk("casc.reset", {24'd0, hi_q, lo_q}, 32'h00);
    c_rst = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clock);
      #1;
      chk("casc.bcd", {24'd0, hi_q, lo_q}, 32'(((n % 100) / 10) * 16 + (n % 10)));
      if (n == 100) chk("casc.hi_wrap", 32'(hi_wrap), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
